muldiv_unit: RTL and testbench



---
 rtl/muldiv_unit_if.sv | 20 ++
 rtl/muldiv_unit.sv | 154 +++++++++++++++
 tb/tb_muldiv_unit.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage (master) and the
// iterative multiply/divide unit (slave).
interface muldiv_unit_if #(
   parameter int DATA_W = 32
);
   logic              start;
   logic [1:0]        op;
   logic [DATA_W-1:0] srca;
   logic [DATA_W-1:0] srcb;
   logic              kill;
   logic              busy;
   logic              done;
   logic [DATA_W-1:0] hi;
   logic [DATA_W-1:0] lo;

   modport master (output start, op, srca, srcb, kill,
                   input  busy, done, hi, lo);
   modport slave  (input  start, op, srca, srcb, kill,
                   output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative radix-2 signed/unsigned multiply and restoring divide, HI/LO result.
// Optional MULDIV_ZEROSKIP_EN: a zero operand bypasses the iteration phase.
module muldiv_unit #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = $clog2(DATA_W) + 1
) (
   input logic          clk,
   input logic          rst,
   muldiv_unit_if.slave bus
);
   localparam int W2 = 2 * DATA_W;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              div_q, div_d;
   logic              neg_q, neg_d;
   logic              rneg_q, rneg_d;
   logic              bz_q, bz_d;
   logic [DATA_W-1:0] b_q, b_d;
   logic [W2-1:0]     acc_q, acc_d;
   logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;

   // Operand capture: signed ops work on magnitudes; the minimum negative
   // value negates to itself, which is already its correct unsigned magnitude.
   logic              in_div, in_sgn, sa, sb;
   logic [DATA_W-1:0] abs_a, abs_b;

   assign in_div = bus.op[1];
   assign in_sgn = ~bus.op[0];
   assign sa     = in_sgn & bus.srca[DATA_W-1];
   assign sb     = in_sgn & bus.srcb[DATA_W-1];
   assign abs_a  = sa ? -bus.srca : bus.srca;
   assign abs_b  = sb ? -bus.srcb : bus.srcb;

   // Multiply step: add multiplier to the upper half when LSB set, shift right.
   logic [DATA_W:0] mul_sum;
   logic [W2-1:0]   mul_next;

   assign mul_sum  = {1'b0, acc_q[W2-1:DATA_W]} + {1'b0, (acc_q[0] ? b_q : '0)};
   assign mul_next = {mul_sum, acc_q[DATA_W-1:1]};

   // Restoring divide step: acc = {remainder, dividend/quotient}.
   logic [DATA_W:0] div_top, div_diff;
   logic            div_ok;
   logic [W2-1:0]   div_next;

   assign div_top  = acc_q[W2-1:DATA_W-1];
   assign div_ok   = div_top >= {1'b0, b_q};
   assign div_diff = div_top - {1'b0, b_q};
   assign div_next = {(div_ok ? div_diff[DATA_W-1:0] : div_top[DATA_W-1:0]),
                      acc_q[DATA_W-2:0], div_ok};

   // Sign correction applied in FIX.
   logic [W2-1:0]     prod_fix;
   logic [DATA_W-1:0] quo_fix, rem_fix;

   assign prod_fix = neg_q ? -acc_q : acc_q;
   assign quo_fix  = bz_q ? '1 : (neg_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0]);
   assign rem_fix  = rneg_q ? -acc_q[W2-1:DATA_W] : acc_q[W2-1:DATA_W];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      div_d   = div_q;
      neg_d   = neg_q;
      rneg_d  = rneg_q;
      bz_d    = bz_q;
      b_d     = b_q;
      acc_d   = acc_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start && !bus.kill) begin
               div_d   = in_div;
               neg_d   = sa ^ sb;
               rneg_d  = in_div & sa;
               bz_d    = in_div & (bus.srcb == '0);
               b_d     = abs_b;
               acc_d   = {{DATA_W{1'b0}}, abs_a};
               cnt_d   = CNT_W'(DATA_W);
               state_d = S_CALC;
`ifdef MULDIV_ZEROSKIP_EN
               if (bus.srca == '0 || bus.srcb == '0) begin
                  // Preload what the full iteration would have left behind.
                  acc_d   = (in_div && bus.srcb == '0) ? {abs_a, {DATA_W{1'b0}}} : '0;
                  cnt_d   = '0;
                  state_d = S_FIX;
               end
`endif
            end
         end
         S_CALC: begin
            acc_d = div_q ? div_next : mul_next;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) state_d = S_FIX;
         end
         S_FIX: begin
            if (div_q) begin
               hi_d = rem_fix;
               lo_d = quo_fix;
            end else begin
               hi_d = prod_fix[W2-1:DATA_W];
               lo_d = prod_fix[DATA_W-1:0];
            end
            state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
      // Flush beats everything; the visible result is left untouched.
      if (state_q != S_IDLE && bus.kill) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         hi_d    = hi_q;
         lo_d    = lo_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         div_q   <= 1'b0;
         neg_q   <= 1'b0;
         rneg_q  <= 1'b0;
         bz_q    <= 1'b0;
         b_q     <= '0;
         acc_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         neg_q   <= neg_d;
         rneg_q  <= rneg_d;
         bz_q    <= bz_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign bus.busy = (state_q != S_IDLE);
   assign bus.done = (state_q == S_DONE);
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: cycle-level behavioural model with per-cycle compare,
// directed literal cases and randomized traffic (start/kill/reset).
module tb_muldiv_unit;
   localparam int W        = 32;
   localparam int FULL_LAT = W + 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   muldiv_unit_if #(.DATA_W(W)) bus ();
   muldiv_unit #(.DATA_W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

   int n_pass  = 0;
   int n_total = 0;
   bit chk_en  = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Architectural result of an operation, from plain integer arithmetic.
   function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
      int sa, sb;
      logic [63:0] r;
      sa = a;
      sb = b;
      case (o)
         2'b00: r = 64'(longint'(sa) * longint'(sb));
         2'b01: r = {32'h0, a} * {32'h0, b};
         2'b10: begin
            if (b == 0) r = {a, 32'hFFFF_FFFF};
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'h0, a};
            else r = {32'(sa % sb), 32'(sa / sb)};
         end
         default: begin
            if (b == 0) r = {a, 32'hFFFF_FFFF};
            else r = {a % b, a / b};
         end
      endcase
      return r;
   endfunction

   function automatic int lat_of(input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_ZEROSKIP_EN
      if (a == 0 || b == 0) return 2;
`endif
      return FULL_LAT;
   endfunction

   // Model: cycles left until the unit is idle again; 1 means the done cycle.
   int          m_rem  = 0;
   logic [31:0] m_hi   = '0;
   logic [31:0] m_lo   = '0;
   logic [63:0] m_pend = '0;

   always @(posedge clk) begin
      if (rst) begin
         m_rem <= 0;
         m_hi  <= '0;
         m_lo  <= '0;
      end else if (m_rem == 0) begin
         if (bus.start && !bus.kill) begin
            m_rem  <= lat_of(bus.srca, bus.srcb);
            m_pend <= ref_result(bus.op, bus.srca, bus.srcb);
         end
      end else if (bus.kill) begin
         m_rem <= 0;
      end else begin
         m_rem <= m_rem - 1;
         if (m_rem == 2) begin
            m_hi <= m_pend[63:32];
            m_lo <= m_pend[31:0];
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("busy", 64'(bus.busy), 64'(m_rem != 0));
         check("done", 64'(bus.done), 64'(m_rem == 1));
         check("hi", 64'(bus.hi), 64'(m_hi));
         check("lo", 64'(bus.lo), 64'(m_lo));
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Presents a request for one cycle, then scrambles the inputs.
   task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      bus.op    = o;
      bus.srca  = a;
      bus.srcb  = b;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      bus.op    = ~o;
      bus.srca  = ~a;
      bus.srcb  = $urandom;
   endtask

   // Returns k such that done is seen in cycle t+k (0 on timeout).
   task automatic wait_done(output int lat, output logic [31:0] h, output logic [31:0] l);
      lat = 0;
      h   = '0;
      l   = '0;
      for (int k = 1; k < 80 && lat == 0; k++) begin
         @(negedge clk);
         if (bus.done) begin
            lat = k;
            h   = bus.hi;
            l   = bus.lo;
         end
         tick();
      end
   endtask

   task automatic do_op(input string nm, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input int elat);
      int lat;
      logic [31:0] h, l;
      launch(o, a, b);
      wait_done(lat, h, l);
      check({nm, "_lat"}, 64'(lat), 64'(elat));
      check({nm, "_hi"}, 64'(h), 64'(eh));
      check({nm, "_lo"}, 64'(l), 64'(el));
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'h1;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int ndone, lat;
      logic [31:0] h, l;
      bus.start = 1'b0;
      bus.kill  = 1'b0;
      bus.op    = '0;
      bus.srca  = '0;
      bus.srcb  = '0;
      rst       = 1'b1;
      repeat (3) tick();
      rst    = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);
      check("rst_busy", 64'(bus.busy), 64'h0);
      check("rst_done", 64'(bus.done), 64'h0);
      check("rst_hi", 64'(bus.hi), 64'h0);
      check("rst_lo", 64'(bus.lo), 64'h0);
      tick();

      do_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'h7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 34);

      // MULTU with a second start mid-flight that must be ignored.
      launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      repeat (4) tick();
      bus.op    = 2'b00;
      bus.srca  = 32'h5;
      bus.srcb  = 32'h5;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      ndone     = 0;
      for (int k = 0; k < 45; k++) begin
         @(negedge clk);
         if (bus.done) begin
            ndone++;
            h = bus.hi;
            l = bus.lo;
         end
         tick();
      end
      check("multu_ndone", 64'(ndone), 64'd1);
      check("multu_hi", 64'(h), 64'hFFFF_FFFE);
      check("multu_lo", 64'(l), 64'h0000_0001);

      do_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34);
      do_op("divu_z", 2'b11, 32'h64, 32'h0, 32'h64, 32'hFFFF_FFFF, lat_of(32'h64, 32'h0));
      do_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 34);
`ifdef MULDIV_ZEROSKIP_EN
      do_op("multu_zero", 2'b01, 32'h0, 32'h1234, 32'h0, 32'h0, 2);
`else
      do_op("multu_zero", 2'b01, 32'h0, 32'h1234, 32'h0, 32'h0, 34);
`endif

      // Kill mid-operation: result of the earlier MULT survives.
      do_op("mult_2x3", 2'b00, 32'h2, 32'h3, 32'h0, 32'h6, 34);
      launch(2'b11, 32'h9, 32'h2);
      repeat (9) tick();
      bus.kill = 1'b1;
      tick();
      bus.kill = 1'b0;
      @(negedge clk);
      check("kill_busy", 64'(bus.busy), 64'h0);
      check("kill_hi", 64'(bus.hi), 64'h0);
      check("kill_lo", 64'(bus.lo), 64'h6);
      ndone = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (bus.done) ndone++;
      end
      check("kill_ndone", 64'(ndone), 64'd0);
      tick();

      // Reset mid-operation clears everything.
      do_op("mult_2x3b", 2'b00, 32'h2, 32'h3, 32'h0, 32'h6, 34);
      launch(2'b11, 32'h9, 32'h2);
      repeat (9) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("rst_mid_busy", 64'(bus.busy), 64'h0);
      check("rst_mid_hi", 64'(bus.hi), 64'h0);
      check("rst_mid_lo", 64'(bus.lo), 64'h0);
      tick();

      // Kill together with start in IDLE: nothing happens.
      bus.kill = 1'b1;
      launch(2'b01, 32'h3, 32'h3);
      bus.kill = 1'b0;
      @(negedge clk);
      check("kill_start_busy", 64'(bus.busy), 64'h0);
      tick();

      do_op("divu_9_2", 2'b11, 32'h9, 32'h2, 32'h1, 32'h4, 34);

      // Randomized traffic; the per-cycle compare does the checking.
      for (int c = 0; c < 5000; c++) begin
         bus.start = ($urandom_range(0, 2) == 0);
         bus.kill  = ($urandom_range(0, 59) == 0);
         rst       = ($urandom_range(0, 1999) == 0);
         bus.op    = 2'($urandom);
         bus.srca  = pick();
         bus.srcb  = pick();
         tick();
      end
      bus.start = 1'b0;
      bus.kill  = 1'b0;
      rst       = 1'b0;
      repeat (40) tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
